grain_prog_loader: RTL and testbench
====================================

// Module: grain_prog_loader
// PURPOSE
//  Parametrised successor to the single-chain serial programming port of the GrainFlex top level.
//  Samples the asynchronous programming pins (clk/rst/en/din) in the system clock domain.
//  Deserialises the bitstream and drives CHAINS parallel configuration shift chains.
//  Provides serial readback, holds the fabric in reset until loading completes, and flags errors.
// PARAMETERS
//  CHAINS       4    number of parallel config chains; one bit per chain per shift
//  CHAIN_LEN    256  shifts (words) needed to fill every chain
//  SYNC_STAGES  2    synchroniser depth on each programming pin (>=2)
// PORTS
//  clk           in   1       system clock; the only clock in the block
//  reset         in   1       asynchronous, active-high reset
//  prog_clk_pin  in   1       external programming clock, async to clk
//  prog_rst_pin  in   1       external programming reset, active-high, async
//  prog_en_pin   in   1       external load enable, async
//  prog_din_pin  in   1       external serial bitstream input, async
//  prog_dout_pin out  1       serial readback of chain tails
//  cfg_shift     out  1       one-cycle pulse; every chain shifts by one
//  cfg_din       out  CHAINS  bit shifted into chain i on cfg_shift
//  cfg_dout      in   CHAINS  tail bit of chain i
//  fabric_rst    out  1       high while the fabric is unconfigured
//  prog_done     out  1       configuration loaded and accepted
//  prog_err      out  1       sticky load error
// BEHAVIOUR
//  Reset values: prog_dout_pin=0, cfg_shift=0, cfg_din=0, fabric_rst=1, prog_done=0, prog_err=0.
//  - All four pins pass through SYNC_STAGES flops. A bit event is a 0->1 transition of synced prog_clk.
//  - Pin-clock high and low phases must each last >=2 clk cycles.
//  - FSM: IDLE, LOAD, CHECK, DONE, ERR.
//  - IDLE: synced en high -> LOAD. Bit counter, word counter and assembly register are cleared.
//  - LOAD: each bit event with en high shifts din into a CHAINS-bit assembly register.
//    - The first bit of a word goes to chain 0, the last to chain CHAINS-1.
//    - After the CHAINS-th bit, the word is registered onto cfg_din and cfg_shift pulses the next cycle (latency 1).
//    - The word counter ($clog2(CHAIN_LEN+1) bits) then increments.
//    - Word counter reaching CHAIN_LEN -> CHECK.
//  - Readback: on each cfg_shift, cfg_dout is captured into a tail register.
//    - prog_dout_pin = tail[bit index] of the word being assembled, registered.
//    - A loader can shift in a new image while reading out the old one.
//  - Synced en falls in LOAD -> ERR. This applies with a partial word or with fewer than CHAIN_LEN words.
//  - CHECK: behaviour depends on the macro (see CONFIGURATION).
//  - DONE: prog_done=1. fabric_rst drops 1 cycle after entry. Bit events with en high -> ERR (overrun).
//  - ERR: prog_err=1, fabric_rst=1, prog_done=0. The state holds until prog_rst or reset.
//  - Synced prog_rst high -> IDLE from any state. This clears counters, prog_err and prog_done, and sets fabric_rst=1.
//    - prog_rst wins over a simultaneous bit event. No cfg_shift is issued while it is high.
//  - Asynchronous reset mid-load aborts immediately. Any partial word is discarded and no shift is emitted.
//  - The word counter never wraps. Words beyond CHAIN_LEN are overrun errors, never extra shifts.
// CONFIGURATION
//  PROG_CRC_EN defined:
//  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) runs over every data bit in arrival order.
//  - In CHECK, 16 more bit events are shifted in as the expected CRC; en must stay high during them.
//  - Match -> DONE; mismatch or en falling -> ERR.
//  PROG_CRC_EN undefined:
//  - No CRC logic. CHECK lasts exactly one cycle, then -> DONE.
//  - Port list is identical in both builds.
// TESTING  (CHAINS=4, CHAIN_LEN=8 unless noted)
//  1. Reset, then 32 bits 0xA5A5_A5A5 MSB first with en high.
//     -> 8 cfg_shift pulses; first cfg_din=4'b0101; prog_done=1; fabric_rst falls 1 cycle later.
//  2. Preload all chains with ones (cfg_dout=4'hF), then load a new image.
//     -> prog_dout_pin reads 1 for all 32 bit slots.
//  3. en dropped after 13 bits.
//     -> 3 shifts issued, prog_err=1, fabric_rst=1. Then prog_rst pulse -> IDLE with prog_err=0.
//  4. Successful load, then 1 extra bit event with en high -> prog_err=1, prog_done=0.
//  5. prog_rst asserted on the same cycle as the 4th bit event of word 0.
//     -> no cfg_shift; IDLE; word counter=0.
//  6. PROG_CRC_EN: 32 data bits + correct CRC -> DONE; same data with CRC bit 0 flipped -> ERR.

Source files
------------

// File: rtl/grain_prog_loader_if.sv
// Configuration-chain bus between the programming loader and the fabric's parallel shift chains.
interface grain_prog_loader_if #(
   parameter int unsigned CHAINS = 4
);
   logic              cfg_shift;
   logic [CHAINS-1:0] cfg_din;
   logic [CHAINS-1:0] cfg_dout;

   modport master (output cfg_shift, output cfg_din, input cfg_dout);
   modport slave  (input cfg_shift, input cfg_din, output cfg_dout);
endinterface

// File: rtl/grain_prog_loader.sv
// Serial programming port: synchronises the async pins, deserialises onto CHAINS config chains, reads back tails.
// Build option: define PROG_CRC_EN to require a trailing CRC-16-CCITT over the bitstream before DONE.
module grain_prog_loader #(
   parameter int unsigned CHAINS      = 4,
   parameter int unsigned CHAIN_LEN   = 256,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                prog_clk_pin,
   input  logic                prog_rst_pin,
   input  logic                prog_en_pin,
   input  logic                prog_din_pin,
   output logic                prog_dout_pin,
   grain_prog_loader_if.master cfg,
   output logic                fabric_rst,
   output logic                prog_done,
   output logic                prog_err
);
   localparam int unsigned BIT_W  = (CHAINS > 1) ? $clog2(CHAINS) : 1;
   localparam int unsigned WORD_W = $clog2(CHAIN_LEN + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;

   state_t                      state_q, state_d;
   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic                        pclk_prev_q, pclk_prev_d;
   logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0]           word_cnt_q, word_cnt_d;
   logic [CHAINS-1:0]           asm_q, asm_d;
   logic [CHAINS-1:0]           cfg_din_q, cfg_din_d;
   logic                        cfg_shift_q, cfg_shift_d;
   logic                        shift_seen_q, shift_seen_d;
   logic [CHAINS-1:0]           tail_q, tail_d;
   logic                        prog_dout_q, prog_dout_d;
   logic                        fabric_rst_q, fabric_rst_d;
   logic                        prog_done_q, prog_done_d;
   logic                        prog_err_q, prog_err_d;
`ifdef PROG_CRC_EN
   logic [15:0]                 crc_q, crc_d;
   logic [15:0]                 crc_rx_q, crc_rx_d;
   logic [3:0]                  crc_cnt_q, crc_cnt_d;
`endif

   logic pclk_s, prst_s, pen_s, pdin_s, bit_ev;

   assign pclk_s = sync_q[SYNC_STAGES-1][0];
   assign prst_s = sync_q[SYNC_STAGES-1][1];
   assign pen_s  = sync_q[SYNC_STAGES-1][2];
   assign pdin_s = sync_q[SYNC_STAGES-1][3];
   assign bit_ev = pclk_s & ~pclk_prev_q;

   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0],
                      {prog_din_pin, prog_en_pin, prog_rst_pin, prog_clk_pin}};
      pclk_prev_d  = pclk_s;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      asm_d        = asm_q;
      cfg_din_d    = cfg_din_q;
      cfg_shift_d  = 1'b0;
      shift_seen_d = cfg_shift_q;
      tail_d       = tail_q;
      prog_dout_d  = 1'b0;
`ifdef PROG_CRC_EN
      crc_d        = crc_q;
      crc_rx_d     = crc_rx_q;
      crc_cnt_d    = crc_cnt_q;
`endif
      // Capture chain tails the cycle after a shift, once the chains have moved.
      if (shift_seen_q) tail_d = cfg.cfg_dout;

      if (prst_s) begin
         state_d    = S_IDLE;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         asm_d      = '0;
      end else begin
         case (state_q)
            S_IDLE: if (pen_s) begin
               state_d    = S_LOAD;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               asm_d      = '0;
               tail_d     = cfg.cfg_dout;
`ifdef PROG_CRC_EN
               crc_d      = 16'hFFFF;
               crc_cnt_d  = 4'd0;
`endif
            end
            S_LOAD: begin
               prog_dout_d = tail_q[bit_cnt_q];
               if (!pen_s) begin
                  state_d = S_ERR;
               end else if (bit_ev) begin
                  asm_d[bit_cnt_q] = pdin_s;
`ifdef PROG_CRC_EN
                  crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ pdin_s) ? 16'h1021 : 16'h0000);
`endif
                  if (bit_cnt_q == BIT_W'(CHAINS - 1)) begin
                     bit_cnt_d   = '0;
                     cfg_din_d   = asm_d;
                     cfg_shift_d = 1'b1;
                     word_cnt_d  = word_cnt_q + WORD_W'(1);
                     if (word_cnt_q == WORD_W'(CHAIN_LEN - 1)) state_d = S_CHECK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            S_CHECK: begin
`ifdef PROG_CRC_EN
               if (!pen_s) begin
                  state_d = S_ERR;
               end else if (bit_ev) begin
                  crc_rx_d  = {crc_rx_q[14:0], pdin_s};
                  crc_cnt_d = crc_cnt_q + 4'd1;
                  if (crc_cnt_q == 4'd15) state_d = (crc_rx_d == crc_q) ? S_DONE : S_ERR;
               end
`else
               state_d = S_DONE;
`endif
            end
            S_DONE:  if (bit_ev && pen_s) state_d = S_ERR;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
      end

      // Status follows the next state; fabric reset releases one cycle into DONE.
      prog_done_d  = (state_d == S_DONE);
      prog_err_d   = (state_d == S_ERR);
      fabric_rst_d = !((state_q == S_DONE) && (state_d == S_DONE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q       <= '0;
         pclk_prev_q  <= 1'b0;
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         asm_q        <= '0;
         cfg_din_q    <= '0;
         cfg_shift_q  <= 1'b0;
         shift_seen_q <= 1'b0;
         tail_q       <= '0;
         prog_dout_q  <= 1'b0;
         fabric_rst_q <= 1'b1;
         prog_done_q  <= 1'b0;
         prog_err_q   <= 1'b0;
`ifdef PROG_CRC_EN
         crc_q        <= 16'hFFFF;
         crc_rx_q     <= '0;
         crc_cnt_q    <= '0;
`endif
      end else begin
         sync_q       <= sync_d;
         pclk_prev_q  <= pclk_prev_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         asm_q        <= asm_d;
         cfg_din_q    <= cfg_din_d;
         cfg_shift_q  <= cfg_shift_d;
         shift_seen_q <= shift_seen_d;
         tail_q       <= tail_d;
         prog_dout_q  <= prog_dout_d;
         fabric_rst_q <= fabric_rst_d;
         prog_done_q  <= prog_done_d;
         prog_err_q   <= prog_err_d;
`ifdef PROG_CRC_EN
         crc_q        <= crc_d;
         crc_rx_q     <= crc_rx_d;
         crc_cnt_q    <= crc_cnt_d;
`endif
      end
   end

   assign cfg.cfg_shift   = cfg_shift_q;
   assign cfg.cfg_din     = cfg_din_q;
   assign prog_dout_pin   = prog_dout_q;
   assign fabric_rst      = fabric_rst_q;
   assign prog_done       = prog_done_q;
   assign prog_err        = prog_err_q;
endmodule

// File: tb/tb_grain_prog_loader.sv
// Bench for grain_prog_loader (CHAINS=4, CHAIN_LEN=8): vector table plus cfg_din scoreboard and corner sequences.
`timescale 1ns/1ps
module tb_grain_prog_loader;
   localparam int unsigned CHAINS    = 4;
   localparam int unsigned CHAIN_LEN = 8;

   logic clk = 1'b0;
   logic reset;
   logic pclk, prst, pen, pdin;
   logic prog_dout, fabric_rst, prog_done, prog_err;
   logic [CHAINS-1:0] cfg_dout_r;

   grain_prog_loader_if #(.CHAINS(CHAINS)) cfg_if ();
   assign cfg_if.cfg_dout = cfg_dout_r;

   grain_prog_loader #(.CHAINS(CHAINS), .CHAIN_LEN(CHAIN_LEN), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .prog_clk_pin  (pclk),
      .prog_rst_pin  (prst),
      .prog_en_pin   (pen),
      .prog_din_pin  (pdin),
      .prog_dout_pin (prog_dout),
      .cfg           (cfg_if),
      .fabric_rst    (fabric_rst),
      .prog_done     (prog_done),
      .prog_err      (prog_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] image;
      int          nbits;
      bit          drop_en;
      bit          extra;
      logic [3:0]  dout;
      bit          bad_crc;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every cfg_shift must match the next expected word.
   always @(negedge clk) begin
      if (!reset && cfg_if.cfg_shift === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_shift: cfg_din=%b with no word pending (t=%0t)", cfg_if.cfg_din, $time);
         end else begin
            check("cfg_din", 32'(cfg_if.cfg_din), 32'(exp_q.pop_front()));
         end
      end
   end

   // fabric_rst stays high on the first DONE cycle and drops on the next.
   logic done_p1 = 1'b0, done_p2 = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (prog_done === 1'b1 && done_p1 !== 1'b1) check("frst_at_done", 32'(fabric_rst), 32'd1);
         else if (prog_done === 1'b1 && done_p1 === 1'b1 && done_p2 !== 1'b1)
            check("frst_after_done", 32'(fabric_rst), 32'd0);
      end
      done_p2 = done_p1;
      done_p1 = prog_done;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit chk, input logic rb);
      pdin = b;
      cyc(4);
      if (chk) check("readback", 32'(prog_dout), 32'(rb));
      pclk = 1'b1;
      cyc(4);
      pclk = 1'b0;
   endtask

   task automatic load_bits(input logic [31:0] img, input int n, input bit chk, input logic [3:0] rb);
      logic [3:0] w;
      for (int i = 0; i < n; i++) begin
         if (i % 4 == 3) begin
            for (int k = 0; k < 4; k++) w[k] = img[31 - (i - 3) - k];
            exp_q.push_back(w);
         end
         send_bit(img[31 - i], chk, rb[i % 4]);
      end
   endtask

`ifdef PROG_CRC_EN
   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < 32; i++)
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[31 - i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   task automatic send_crc(input logic [15:0] c);
      for (int i = 0; i < 16; i++) send_bit(c[15 - i], 1'b0, 1'b0);
   endtask
`endif

   task automatic wait_done();
      int n = 0;
      while (prog_done !== 1'b1 && n < 60) begin
         cyc(1);
         n++;
      end
      check("done_reached", 32'(prog_done), 32'd1);
   endtask

   task automatic prog_rst_pulse();
      prst = 1'b1;
      cyc(4);
      prst = 1'b0;
      cyc(4);
   endtask

   task automatic run_vec(input vec_t v);
      pen        = 1'b0;
      cfg_dout_r = v.dout;
      prog_rst_pulse();
      pen = 1'b1;
      cyc(6);
      load_bits(v.image, v.nbits, 1'b1, v.dout);
      if (v.nbits == 32) begin
`ifdef PROG_CRC_EN
         send_crc(crc16(v.image) ^ {15'd0, v.bad_crc});
`endif
         if (!v.bad_crc) wait_done();
      end
      if (v.extra) send_bit(1'b1, 1'b0, 1'b0);
      if (v.drop_en) pen = 1'b0;
      cyc(8);
      check("shifts_missing", 32'(exp_q.size()), 32'd0);
      check("prog_done", 32'(prog_done), 32'(v.exp_done));
      check("prog_err", 32'(prog_err), 32'(v.exp_err));
      check("fabric_rst", 32'(fabric_rst), 32'(!v.exp_done));
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; pclk = 1'b0; prst = 1'b0; pen = 1'b0; pdin = 1'b0; cfg_dout_r = '0;

      //           image         nbits drop extra dout  bad done err
      vecs.push_back('{32'hA5A5_A5A5, 32, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'h3C96_F00F, 32, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'hDEAD_BEEF, 13, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{32'h0F0F_1234, 32, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF,  4, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1});
`ifdef PROG_CRC_EN
      vecs.push_back('{32'hA5A5_A5A5, 32, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
`endif

      cyc(3);
      check("rst_prog_dout", 32'(prog_dout), 32'd0);
      check("rst_cfg_shift", 32'(cfg_if.cfg_shift), 32'd0);
      check("rst_cfg_din", 32'(cfg_if.cfg_din), 32'd0);
      check("rst_fabric_rst", 32'(fabric_rst), 32'd1);
      check("rst_prog_done", 32'(prog_done), 32'd0);
      check("rst_prog_err", 32'(prog_err), 32'd0);
      reset = 1'b0;
      cyc(3);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Partial load aborted by en, then cleared by a prog_rst pulse.
      run_vec(vecs[2]);
      prst = 1'b1;
      cyc(4);
      check("prst_err_clear", 32'(prog_err), 32'd0);
      check("prst_done_clear", 32'(prog_done), 32'd0);
      check("prst_frst", 32'(fabric_rst), 32'd1);
      prst = 1'b0;
      cyc(4);

      // prog_rst lands on the same cycle as the 4th bit event of word 0.
      cfg_dout_r = 4'h0;
      pen = 1'b1;
      cyc(6);
      load_bits(32'h8000_0000, 3, 1'b0, 4'h0);
      pdin = 1'b1;
      cyc(4);
      pclk = 1'b1;
      prst = 1'b1;
      cyc(4);
      pclk = 1'b0;
      cyc(4);
      check("prst_bit_done", 32'(prog_done), 32'd0);
      check("prst_bit_frst", 32'(fabric_rst), 32'd1);
      prst = 1'b0;
      cyc(6);
      load_bits(32'hA5A5_A5A5, 32, 1'b1, 4'h0);
      wait_done();
      cyc(4);
      check("reload_shifts", 32'(exp_q.size()), 32'd0);
      check("reload_err", 32'(prog_err), 32'd0);
      exp_q.delete();

      // Asynchronous reset in the middle of a word.
      pen = 1'b0;
      prog_rst_pulse();
      cfg_dout_r = 4'h3;
      pen = 1'b1;
      cyc(6);
      load_bits(32'h1234_5678, 6, 1'b1, 4'h3);
      pen   = 1'b0;
      reset = 1'b1;
      cyc(1);
      check("arst_cfg_din", 32'(cfg_if.cfg_din), 32'd0);
      check("arst_cfg_shift", 32'(cfg_if.cfg_shift), 32'd0);
      check("arst_done", 32'(prog_done), 32'd0);
      check("arst_err", 32'(prog_err), 32'd0);
      check("arst_frst", 32'(fabric_rst), 32'd1);
      cyc(2);
      check("arst_pending", 32'(exp_q.size()), 32'd0);
      reset = 1'b0;
      cyc(2);
      pen = 1'b1;
      cyc(6);
      load_bits(32'h5A5A_5A5A, 32, 1'b1, 4'h3);
`ifdef PROG_CRC_EN
      send_crc(crc16(32'h5A5A_5A5A));
`endif
      wait_done();
      cyc(4);
      check("post_arst_shifts", 32'(exp_q.size()), 32'd0);
      check("post_arst_err", 32'(prog_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
